// File: rtl/grid_run_ctrl.sv
// grid_run_ctrl: run sequencer between the board start key and the grid solver.
// Each attempt clears the grid, pulses rq_start and watches done/success under a
// watchdog. Failed or timed-out attempts are retried with a stepped seed until the
// try budget is used up. The final status, attempt and seed are held for display.
module grid_run_ctrl #(
  parameter int                SEED_W      = 8,
  parameter int                MAX_TRIES   = 4,
  parameter int                TIMEOUT_CYC = 2**24,
  parameter logic [SEED_W-1:0] SEED_STEP   = SEED_W'(8'h35)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_btn,
  input  logic [SEED_W-1:0] base_seed,
  output logic              grid_reset,
  output logic [SEED_W-1:0] grid_seed,
  output logic              grid_rq_start,
  input  logic              grid_done,
  input  logic              grid_success,
  output logic [1:0]        status,
  output logic [3:0]        attempt
);

  localparam int            TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    LAST_TRY   = 4'(MAX_TRIES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WORKING = 2'd1;
  localparam logic [1:0] ST_SUCCESS = 2'd2;
  localparam logic [1:0] ST_FAILURE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_PASS,
    S_FAIL
  } state_t;

  state_t            state_reg;
  logic              start_q_reg;
  logic              clr_cnt_reg;
  logic [TW-1:0]     timer_reg;
  logic [3:0]        attempt_reg;
  logic [SEED_W-1:0] seed_reg;
  logic              grid_reset_reg;
  logic              rq_start_reg;
  logic [1:0]        status_reg;
  logic              start_edge;

  // Rising edge of the (already synchronised) start key; start_q resets high so a
  // key held through reset does not count as a press.
  assign start_edge = start_btn & ~start_q_reg;

  // Sequencer: state, counters and every output are registered together here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      start_q_reg    <= 1'b1;
      clr_cnt_reg    <= 1'b0;
      timer_reg      <= '0;
      attempt_reg    <= 4'd0;
      seed_reg       <= '0;
      grid_reset_reg <= 1'b0;
      rq_start_reg   <= 1'b0;
      status_reg     <= ST_IDLE;
    end else begin
      start_q_reg  <= start_btn;
      rq_start_reg <= 1'b0;
      case (state_reg)
        // Idle and both final states accept a new run; start edges elsewhere are ignored.
        S_IDLE, S_PASS, S_FAIL: begin
          if (start_edge) begin
            state_reg      <= S_CLEAR;
            clr_cnt_reg    <= 1'b0;
            attempt_reg    <= 4'd0;
            seed_reg       <= base_seed;
            grid_reset_reg <= 1'b1;
            status_reg     <= ST_WORKING;
          end
        end
        // Two cycles of grid reset; grid_done here is a stale result and is ignored.
        S_CLEAR: begin
          if (clr_cnt_reg) begin
            state_reg      <= S_START;
            grid_reset_reg <= 1'b0;
            rq_start_reg   <= 1'b1;
            timer_reg      <= '0;
          end else begin
            clr_cnt_reg <= 1'b1;
          end
        end
        S_START: begin
          state_reg <= S_WAIT;
          timer_reg <= '0;
        end
        // A done in the same cycle as the watchdog expiry wins over the timeout.
        S_WAIT: begin
          if (grid_done && grid_success) begin
            state_reg  <= S_PASS;
            status_reg <= ST_SUCCESS;
          end else if (grid_done || (timer_reg == TIMER_LAST)) begin
            if (attempt_reg < LAST_TRY) begin
              state_reg      <= S_CLEAR;
              clr_cnt_reg    <= 1'b0;
              attempt_reg    <= attempt_reg + 4'd1;
              seed_reg       <= seed_reg + SEED_STEP;
              grid_reset_reg <= 1'b1;
            end else begin
              state_reg  <= S_FAIL;
              status_reg <= ST_FAILURE;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          state_reg      <= S_IDLE;
          grid_reset_reg <= 1'b0;
          status_reg     <= ST_IDLE;
        end
      endcase
    end
  end

  assign grid_reset    = grid_reset_reg;
  assign grid_seed     = seed_reg;
  assign grid_rq_start = rq_start_reg;
  assign status        = status_reg;
  assign attempt       = attempt_reg;

endmodule

// File: tb/tb_grid_run_ctrl.sv
// Directed bench for grid_run_ctrl with a small try budget and short watchdog.
module tb_grid_run_ctrl;

  logic       clock;
  logic       reset;
  logic       start_btn;
  logic [7:0] base_seed;
  logic       grid_reset;
  logic [7:0] grid_seed;
  logic       grid_rq_start;
  logic       grid_done;
  logic       grid_success;
  logic [1:0] status;
  logic [3:0] attempt;

  int n_pass  = 0;
  int n_total = 0;

  // Observation log filled on falling edges: grid_reset cycles, rq pulses, seed at each rq.
  int         rst_total = 0;
  int         rq_total  = 0;
  logic [7:0] seed_log[$];

  grid_run_ctrl #(
    .SEED_W(8),
    .MAX_TRIES(3),
    .TIMEOUT_CYC(16),
    .SEED_STEP(8'h35)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_btn(start_btn),
    .base_seed(base_seed),
    .grid_reset(grid_reset),
    .grid_seed(grid_seed),
    .grid_rq_start(grid_rq_start),
    .grid_done(grid_done),
    .grid_success(grid_success),
    .status(status),
    .attempt(attempt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Sample the grid-side outputs mid-cycle.
  always @(negedge clock) begin
    if (grid_reset === 1'b1) rst_total++;
    if (grid_rq_start === 1'b1) begin
      rq_total++;
      seed_log.push_back(grid_seed);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Bounded wait for the rq_start pulse; an expired bound is a failed check.
  task automatic wait_rq(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (grid_rq_start === 1'b1) found = 1'b1;
      else step();
    end
    n_total++;
    if (!found) $display("FAIL %s rq_wait: got no rq_start expected rq_start within 30 cycles", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_btn = 1'b0; base_seed = 8'h00; grid_done = 1'b0; grid_success = 1'b0;
    step(); step();
    n_total++; if (status !== 2'd0) $display("FAIL reset_status: got %0d expected 0", status); else n_pass++;
    n_total++; if (attempt !== 4'd0) $display("FAIL reset_attempt: got %0d expected 0", attempt); else n_pass++;
    n_total++; if (grid_seed !== 8'h00) $display("FAIL reset_seed: got %h expected 00", grid_seed); else n_pass++;
    n_total++; if (grid_reset !== 1'b0) $display("FAIL reset_grid_reset: got %b expected 0", grid_reset); else n_pass++;
    n_total++; if (grid_rq_start !== 1'b0) $display("FAIL reset_rq: got %b expected 0", grid_rq_start); else n_pass++;
    reset = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_success();
    int r0 = rst_total;
    int q0 = rq_total;
    int s0 = seed_log.size();
    base_seed = 8'h10;
    press();
    base_seed = 8'hAA;  // late change must not affect this run
    n_total++; if (status !== 2'd1) $display("FAIL t1_status_working: got %0d expected 1", status); else n_pass++;
    wait_rq("t1");
    step();
    for (int i = 0; i < 4; i++) step();
    n_total++; if (status !== 2'd1) $display("FAIL t1_status_wait: got %0d expected 1", status); else n_pass++;
    grid_done = 1'b1; grid_success = 1'b1;
    step();
    grid_done = 1'b0; grid_success = 1'b0;
    n_total++; if (status !== 2'd2) $display("FAIL t1_status_pass: got %0d expected 2", status); else n_pass++;
    n_total++; if (attempt !== 4'd0) $display("FAIL t1_attempt: got %0d expected 0", attempt); else n_pass++;
    n_total++; if (grid_seed !== 8'h10) $display("FAIL t1_seed: got %h expected 10", grid_seed); else n_pass++;
    n_total++; if (rst_total - r0 !== 2) $display("FAIL t1_reset_cycles: got %0d expected 2", rst_total - r0); else n_pass++;
    n_total++; if (rq_total - q0 !== 1) $display("FAIL t1_rq_count: got %0d expected 1", rq_total - q0); else n_pass++;
    n_total++;
    if (seed_log.size() <= s0 || seed_log[s0] !== 8'h10) $display("FAIL t1_rq_seed: got log size %0d expected seed 10 at rq", seed_log.size() - s0);
    else n_pass++;
    $display("test_success done: status=%0d attempt=%0d seed=%h", status, attempt, grid_seed);
  endtask

  task automatic test_all_fail();
    logic [7:0] exp_seed[3] = '{8'h10, 8'h45, 8'h7A};
    int r0 = rst_total;
    int q0 = rq_total;
    int s0 = seed_log.size();
    logic [7:0] got;
    base_seed = 8'h10;
    press();
    for (int a = 0; a < 3; a++) begin
      wait_rq("t2");
      step();
      grid_done = 1'b1; grid_success = 1'b0;
      step();
      grid_done = 1'b0;
    end
    n_total++; if (status !== 2'd3) $display("FAIL t2_status: got %0d expected 3", status); else n_pass++;
    n_total++; if (attempt !== 4'd2) $display("FAIL t2_attempt: got %0d expected 2", attempt); else n_pass++;
    n_total++; if (rq_total - q0 !== 3) $display("FAIL t2_rq_count: got %0d expected 3", rq_total - q0); else n_pass++;
    n_total++; if (rst_total - r0 !== 6) $display("FAIL t2_reset_cycles: got %0d expected 6", rst_total - r0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      got = (seed_log.size() > s0 + i) ? seed_log[s0 + i] : 8'hxx;
      n_total++; if (got !== exp_seed[i]) $display("FAIL t2_seed%0d: got %h expected %h", i, got, exp_seed[i]); else n_pass++;
    end
    $display("test_all_fail done: status=%0d attempt=%0d", status, attempt);
  endtask

  task automatic test_timeout_wrap();
    int s0 = seed_log.size();
    logic [7:0] got;
    base_seed = 8'hF0;
    press();
    wait_rq("t3");
    step();
    for (int i = 0; i < 15; i++) step();
    n_total++; if (grid_reset !== 1'b0) $display("FAIL t3_early_timeout: got grid_reset %b expected 0", grid_reset); else n_pass++;
    n_total++; if (status !== 2'd1) $display("FAIL t3_status_wait: got %0d expected 1", status); else n_pass++;
    step();
    n_total++; if (grid_reset !== 1'b1) $display("FAIL t3_timeout_clear: got grid_reset %b expected 1", grid_reset); else n_pass++;
    n_total++; if (grid_seed !== 8'h25) $display("FAIL t3_wrap_seed: got %h expected 25", grid_seed); else n_pass++;
    wait_rq("t3b");
    step();
    grid_done = 1'b1; grid_success = 1'b1;
    step();
    grid_done = 1'b0; grid_success = 1'b0;
    n_total++; if (status !== 2'd2) $display("FAIL t3_status: got %0d expected 2", status); else n_pass++;
    n_total++; if (attempt !== 4'd1) $display("FAIL t3_attempt: got %0d expected 1", attempt); else n_pass++;
    got = (seed_log.size() > s0 + 1) ? seed_log[s0 + 1] : 8'hxx;
    n_total++; if (got !== 8'h25) $display("FAIL t3_rq_seed1: got %h expected 25", got); else n_pass++;
    $display("test_timeout_wrap done: status=%0d attempt=%0d", status, attempt);
  endtask

  task automatic test_held_button();
    int r0;
    reset = 1'b1; start_btn = 1'b1;
    step(); step();
    r0 = rst_total;
    reset = 1'b0;
    step(); step(); step();
    n_total++; if (status !== 2'd0) $display("FAIL t4_status_held: got %0d expected 0", status); else n_pass++;
    n_total++; if (rst_total - r0 !== 0) $display("FAIL t4_no_grid_reset: got %0d cycles expected 0", rst_total - r0); else n_pass++;
    start_btn = 1'b0;
    step();
    base_seed = 8'h5C;
    press();
    n_total++; if (status !== 2'd1) $display("FAIL t4_status_press: got %0d expected 1", status); else n_pass++;
    n_total++; if (grid_reset !== 1'b1) $display("FAIL t4_grid_reset: got %b expected 1", grid_reset); else n_pass++;
    n_total++; if (grid_seed !== 8'h5C) $display("FAIL t4_seed: got %h expected 5C", grid_seed); else n_pass++;
    $display("test_held_button done: status=%0d", status);
  endtask

  task automatic test_ignored_inputs();
    int q0;
    apply_reset();
    q0 = rq_total;
    base_seed = 8'h20;
    press();
    grid_done = 1'b1; grid_success = 1'b0;  // stale result during CLEAR
    step();
    grid_done = 1'b0;
    wait_rq("t5");
    step();
    start_btn = 1'b1;  // press during WAIT
    step();
    start_btn = 1'b0;
    n_total++; if (grid_reset !== 1'b0) $display("FAIL t5_restart_ignored: got grid_reset %b expected 0", grid_reset); else n_pass++;
    n_total++; if (attempt !== 4'd0) $display("FAIL t5_attempt_mid: got %0d expected 0", attempt); else n_pass++;
    for (int i = 0; i < 14; i++) step();
    n_total++; if (status !== 2'd1) $display("FAIL t5_status_mid: got %0d expected 1", status); else n_pass++;
    grid_done = 1'b1; grid_success = 1'b1;  // arrives with timer at its last value
    step();
    grid_done = 1'b0; grid_success = 1'b0;
    n_total++; if (status !== 2'd2) $display("FAIL t5_done_wins: got %0d expected 2", status); else n_pass++;
    n_total++; if (attempt !== 4'd0) $display("FAIL t5_attempt: got %0d expected 0", attempt); else n_pass++;
    n_total++; if (grid_reset !== 1'b0) $display("FAIL t5_no_retry: got grid_reset %b expected 0", grid_reset); else n_pass++;
    n_total++; if (rq_total - q0 !== 1) $display("FAIL t5_rq_count: got %0d expected 1", rq_total - q0); else n_pass++;
    $display("test_ignored_inputs done: status=%0d attempt=%0d", status, attempt);
  endtask

  task automatic test_reset_mid_run();
    int q0;
    base_seed = 8'h30;
    press();
    wait_rq("t6");
    step();
    grid_done = 1'b1; grid_success = 1'b0;
    step();
    grid_done = 1'b0;
    wait_rq("t6b");
    step();
    step();
    n_total++; if (attempt !== 4'd1) $display("FAIL t6_attempt_before: got %0d expected 1", attempt); else n_pass++;
    q0 = rq_total;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_total++; if (status !== 2'd0) $display("FAIL t6_status: got %0d expected 0", status); else n_pass++;
    n_total++; if (attempt !== 4'd0) $display("FAIL t6_attempt: got %0d expected 0", attempt); else n_pass++;
    n_total++; if (grid_seed !== 8'h00) $display("FAIL t6_seed: got %h expected 00", grid_seed); else n_pass++;
    for (int i = 0; i < 6; i++) step();
    n_total++; if (rq_total - q0 !== 0) $display("FAIL t6_no_rq: got %0d pulses expected 0", rq_total - q0); else n_pass++;
    n_total++; if (status !== 2'd0) $display("FAIL t6_status_idle: got %0d expected 0", status); else n_pass++;
    $display("test_reset_mid_run done: status=%0d", status);
  endtask

  initial begin
    test_reset();
    test_success();
    test_all_fail();
    test_timeout_wrap();
    test_held_button();
    test_ignored_inputs();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
